sync_fifo_param: RTL
====================

# sync_fifo_param

Parametrised single-clock FIFO, the successor to the fixed 8-bit/8-entry buffer: configurable data width, depth and almost-full/almost-empty thresholds. It adds read/write acceptance on a full FIFO when both strobes are active, and overflow/underflow error pulses. An optional first-word-fall-through (show-ahead) read port is selected at compile time. It sits between any producer/consumer pair in the same clock domain, e.g. byte streams into a UART or packet framer.

## Interface
- DATA_W, 8: data word width in bits.
- ADDR_W, 3: pointer width; DEPTH = 1 << ADDR_W entries.
- AF_THRESH, DEPTH-2: almost_full asserts when count >= AF_THRESH; legal range 1..DEPTH.
- AE_THRESH, 2: almost_empty asserts when count <= AE_THRESH; legal range 0..DEPTH-1.
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- wr_en  in  1  push request.
- din  in  DATA_W  write data.
- rd_en  in  1  pop request.
- dout  out  DATA_W  read data.
- empty  out  1  count == 0.
- full  out  1  count == DEPTH.
- almost_empty  out  1  count <= AE_THRESH.
- almost_full  out  1  count >= AF_THRESH.
- count  out  ADDR_W+1  number of stored words, 0..DEPTH.
- overflow  out  1  one-cycle pulse: a write was rejected.
- underflow  out  1  one-cycle pulse: a read was rejected.

## Operation
- Write accepted: wr_acc = wr_en && (!full || rd_en). Read accepted: rd_acc = rd_en && !empty.
- On wr_acc: mem[wr_ptr] <= din; wr_ptr increments modulo DEPTH.
- On rd_acc: rd_ptr increments modulo DEPTH.
- count: +1 on wr_acc only; -1 on rd_acc only; unchanged on both or neither.
- Full with wr_en and rd_en: both are accepted and count stays DEPTH. The read returns the oldest word; the write lands in the slot being vacated, and the read uses the old contents.
- Empty with wr_en and rd_en: the write is accepted, the read is rejected, underflow pulses, and count becomes 1.
- overflow <= wr_en && full && !rd_en. underflow <= rd_en && empty. Both are registered and high for exactly one cycle per rejected request.
- Flags decode from the registered count only. There is no combinational path from wr_en or rd_en to any flag.
- Memory is not reset. Pointers, count, dout and error pulses are reset.
- Reset values: count 0, empty 1, full 0, almost_empty 1, almost_full 0, overflow 0, underflow 0, dout 0. Reset mid-operation discards all contents immediately (asynchronously).

## Timing
- Standard mode: dout <= mem[rd_ptr] at the edge where rd_acc is true, so data is valid one cycle after rd_en. dout holds its value otherwise.
- Write-to-visible: a word written at edge N makes empty fall after edge N. It can be popped at edge N+1.
- Flags and count update at the same edge as the accepted operation.
- Error pulses go high the cycle after the offending request.
- Throughput: one push and one pop per cycle, sustained.

## Configuration
- FIFO_FWFT_EN defined: show-ahead mode. dout = mem[rd_ptr] combinationally while !empty, and 0 while empty. rd_en acknowledges the displayed word and advances to the next one. A word written at edge N appears on dout after edge N, so there is zero read latency.
- FIFO_FWFT_EN undefined: standard registered read as described in Timing.
- All other behaviour (flags, count, errors, full/empty simultaneous rules) is identical in both builds.

## Test plan
- Reset, then write 0x11..0x18 (DEPTH=8) -> count 8, full=1, almost_full asserted at count 6. Standard mode: read 8 words -> dout shows 0x11..0x18, each one cycle after its rd_en, then empty=1.
- Full FIFO, pulse wr_en alone with din=0xAA -> overflow high for 1 cycle, count stays 8, and 0xAA never appears on reads.
- Empty FIFO, wr_en and rd_en together with din=0x5C -> underflow pulse, count=1, and the next read returns 0x5C.
- Full FIFO, wr_en and rd_en together for 20 cycles with an incrementing din -> count stays 8, no overflow, and the read sequence is contiguous across pointer wrap.
- Assert rst mid-stream with count=5 -> on the same cycle (async) count=0, empty=1, dout=0, and pulses clear.
- FIFO_FWFT_EN defined: write 0x3C to an empty FIFO -> dout=0x3C after that edge with no rd_en. Then pulse rd_en once -> empty=1 and dout=0.

Source files
------------

// File: rtl/sync_fifo_param.sv
// Parametrised single-clock FIFO with almost-full/almost-empty thresholds and overflow/underflow pulses.
// Define FIFO_FWFT_EN at compile time for a show-ahead (first-word-fall-through) read port.
module sync_fifo_param #(
  parameter int unsigned DATA_W    = 8,
  parameter int unsigned ADDR_W    = 3,
  parameter int unsigned AF_THRESH = (1 << ADDR_W) - 2,
  parameter int unsigned AE_THRESH = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [DATA_W-1:0] din,
  input  logic              rd_en,
  output logic [DATA_W-1:0] dout,
  output logic              empty,
  output logic              full,
  output logic              almost_empty,
  output logic              almost_full,
  output logic [ADDR_W:0]   count,
  output logic              overflow,
  output logic              underflow
);

  localparam int unsigned DEPTH = 1 << ADDR_W;
  localparam int unsigned CNT_W = ADDR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] AF_C    = CNT_W'(AF_THRESH);
  localparam logic [CNT_W-1:0] AE_C    = CNT_W'(AE_THRESH);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              empty_q, empty_d;
  logic              full_q, full_d;
  logic              ae_q, ae_d;
  logic              af_q, af_d;
  logic              ovf_q, ovf_d;
  logic              unf_q, unf_d;
  logic              wr_acc, rd_acc;
`ifndef FIFO_FWFT_EN
  logic [DATA_W-1:0] dout_q, dout_d;
`endif

  // Acceptance, pointer/count update; flags are precomputed from the next count so they stay registered
  always_comb begin
    wr_acc   = wr_en && (!full_q || rd_en);
    rd_acc   = rd_en && !empty_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (wr_acc) wr_ptr_d = wr_ptr_q + ADDR_W'(1);
    if (rd_acc) rd_ptr_d = rd_ptr_q + ADDR_W'(1);
    case ({wr_acc, rd_acc})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
    empty_d = (count_d == '0);
    full_d  = (count_d == DEPTH_C);
    ae_d    = (count_d <= AE_C);
    af_d    = (count_d >= AF_C);
    ovf_d   = wr_en && full_q && !rd_en;
    unf_d   = rd_en && empty_q;
`ifndef FIFO_FWFT_EN
    dout_d  = rd_acc ? mem_q[rd_ptr_q] : dout_q;
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      empty_q  <= 1'b1;
      full_q   <= 1'b0;
      ae_q     <= 1'b1;
      af_q     <= 1'b0;
      ovf_q    <= 1'b0;
      unf_q    <= 1'b0;
`ifndef FIFO_FWFT_EN
      dout_q   <= '0;
`endif
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      empty_q  <= empty_d;
      full_q   <= full_d;
      ae_q     <= ae_d;
      af_q     <= af_d;
      ovf_q    <= ovf_d;
      unf_q    <= unf_d;
`ifndef FIFO_FWFT_EN
      dout_q   <= dout_d;
`endif
    end
  end

  // Storage is deliberately left unreset; a write into a full FIFO reuses the slot the read vacates
  always_ff @(posedge clk) begin
    if (wr_acc) mem_q[wr_ptr_q] <= din;
  end

`ifdef FIFO_FWFT_EN
  assign dout = empty_q ? '0 : mem_q[rd_ptr_q];
`else
  assign dout = dout_q;
`endif

  assign empty        = empty_q;
  assign full         = full_q;
  assign almost_empty = ae_q;
  assign almost_full  = af_q;
  assign count        = count_q;
  assign overflow     = ovf_q;
  assign underflow    = unf_q;

endmodule
